// File: rtl/cnn_pkg.sv
// Shared definitions for the cnn_accel job sequencer.
//   - accelerator register offsets used by the controller
//   - controller state encoding
//   - word stride and a helper to form base + stride*index byte addresses
package cnn_pkg;

    localparam logic [31:0] IMG_ADDR    = 32'h0000_0004;
    localparam logic [31:0] KER_ADDR    = 32'h0000_0008;
    localparam logic [31:0] START_ADDR  = 32'h0000_000C;
    localparam logic [31:0] RES_BASE    = 32'h0000_0080;
    localparam logic [31:0] WORD_STRIDE = 32'd4;

    typedef enum logic [2:0] {
        IDLE,
        LD_IMG,
        LD_KER,
        KICK,
        WAIT,
        RD_RES,
        FIN,
        ERR
    } state_e;

    // Byte address of word 'idx' above 'base'; wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
        return base + WORD_STRIDE * {16'b0, idx};
    endfunction

endpackage

// File: rtl/cnn_ctrl.sv
// cnn_ctrl: runs one convolution job on cnn_accel without CPU help.
// On start it streams IMG_N image bytes then KER_N kernel bytes from the
// source memory into the accelerator, kicks it, waits for acc_done (with a
// timeout), then copies OUT_N result words to the destination memory.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   start               single-cycle job request (honoured in IDLE only)
//   src_base, dst_base  job byte addresses, latched on start
//   busy, done_o        job in flight / one-cycle success pulse
//   err_timeout         sticky timeout flag, cleared by the next start
//   mem_*               source read port (data valid the cycle after mem_re)
//   dst_*               destination write port
//   acc_*               accelerator register write/read port and status
//
// All strobes, addresses and data outputs are decoded from registered
// state, so an asynchronous reset forces them to 0 immediately.
module cnn_ctrl
    import cnn_pkg::*;
#(
    parameter int IMG_N      = 25,
    parameter int KER_N      = 9,
    parameter int OUT_N      = 9,
    parameter int TIMEOUT    = 4096,
    parameter int ACC_RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] src_base,
    input  logic [31:0] dst_base,
    output logic        busy,
    output logic        done_o,
    output logic        err_timeout,
    output logic        mem_re,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        dst_we,
    output logic [31:0] dst_addr,
    output logic [31:0] dst_wdata,
    output logic        acc_cnn_en,
    output logic        acc_w_en,
    output logic [31:0] acc_w_addr,
    output logic [31:0] acc_wdata,
    output logic        acc_r_en,
    output logic [31:0] acc_r_addr,
    input  logic [31:0] acc_rdata,
    input  logic        acc_done
);

    localparam logic [15:0] IMG_LAST = 16'(IMG_N);
    localparam logic [15:0] IMG_N16  = 16'(IMG_N);
    localparam logic [15:0] KER_LAST = 16'(KER_N - 1);
    localparam logic [15:0] OUT_N16  = 16'(OUT_N);
    localparam logic [15:0] RD_LAST  = 16'(OUT_N + ACC_RD_LAT - 1);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;      // element counter shared by LD_IMG/LD_KER/RD_RES
    logic [31:0] tmo_q, tmo_d;      // WAIT cycle counter
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        rd_q, rd_d;        // acc_r_en of the previous cycle
    logic [15:0] cnt_m1;
    logic [15:0] rd_idx;

    logic unused_bits;
    assign unused_bits = ^{mem_rdata[31:8], acc_rdata[31:16]};

    assign cnt_m1      = cnt_q - 16'd1;
    assign busy        = busy_q;
    assign err_timeout = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        src_d      = src_q;
        dst_d      = dst_q;
        busy_d     = busy_q;
        err_d      = err_q;
        rd_idx     = '0;
        mem_re     = 1'b0;
        mem_addr   = '0;
        acc_w_en   = 1'b0;
        acc_w_addr = '0;
        acc_wdata  = '0;
        acc_r_en   = 1'b0;
        acc_r_addr = '0;
        dst_we     = 1'b0;
        dst_addr   = '0;
        dst_wdata  = '0;
        done_o     = 1'b0;
        acc_cnn_en = 1'b1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = src_base;
                    dst_d   = dst_base;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = LD_IMG;
                end
            end

            // Cycle c reads source word c and writes image pixel c-1. The
            // final cycle (c == IMG_N) already reads the first kernel word.
            LD_IMG: begin
                mem_re   = 1'b1;
                mem_addr = word_addr(src_q, cnt_q);
                if (cnt_q != '0) begin
                    acc_w_en   = 1'b1;
                    acc_w_addr = IMG_ADDR;
                    acc_wdata  = {cnt_m1, 8'h00, mem_rdata[7:0]};
                end
                if (cnt_q == IMG_LAST) begin
                    cnt_d   = '0;
                    state_d = LD_KER;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            // Cycle j writes tap j and prefetches tap j+1.
            LD_KER: begin
                if (cnt_q != KER_LAST) begin
                    mem_re   = 1'b1;
                    mem_addr = word_addr(src_q, IMG_N16 + cnt_q + 16'd1);
                end
                acc_w_en   = 1'b1;
                acc_w_addr = KER_ADDR;
                acc_wdata  = {cnt_q, 8'h00, mem_rdata[7:0]};
                if (cnt_q == KER_LAST) begin
                    cnt_d   = '0;
                    state_d = KICK;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            KICK: begin
                acc_w_en   = 1'b1;
                acc_w_addr = START_ADDR;
                acc_wdata  = 32'h1;
                tmo_d      = '0;
                state_d    = WAIT;
            end

            // tmo_q == 0 marks the first WAIT cycle, where acc_done may
            // still be the previous job's level. Done beats timeout.
            WAIT: begin
                if (tmo_q != '0 && acc_done) begin
                    cnt_d   = '0;
                    state_d = RD_RES;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end

            RD_RES: begin
                if (cnt_q < OUT_N16) begin
                    acc_r_en   = 1'b1;
                    acc_r_addr = word_addr(RES_BASE, cnt_q);
                end
                if (ACC_RD_LAT == 0) begin
                    dst_we = acc_r_en;
                    rd_idx = cnt_q;
                end else begin
                    dst_we = rd_q;
                    rd_idx = cnt_m1;
                end
                if (dst_we) begin
                    dst_addr  = word_addr(dst_q, rd_idx);
                    dst_wdata = {16'b0, acc_rdata[15:0]};
                end
                if (cnt_q == RD_LAST) begin
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            FIN: begin
                done_o  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            // One-cycle soft clear of the accelerator.
            ERR: begin
                acc_cnn_en = 1'b0;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end

            default: state_d = IDLE;
        endcase

        rd_d = acc_r_en;
    end

endmodule

// File: tb/tb_cnn_ctrl.sv
// Bench for cnn_ctrl. Instance 0 uses a registered accelerator read
// (ACC_RD_LAT=1), instance 1 a combinational one (ACC_RD_LAT=0). Both use
// TIMEOUT=16. Behavioural models: source memory (associative array),
// accelerator (captures image/kernel, correlates on kick, raises done after
// a delay), and logs of accelerator writes and destination writes.
module tb_cnn_ctrl;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic        start      [2];
    logic [31:0] src_base   [2];
    logic [31:0] dst_base   [2];
    logic        busy       [2];
    logic        done_o     [2];
    logic        err_timeout[2];
    logic        mem_re     [2];
    logic [31:0] mem_addr   [2];
    logic [31:0] mem_rdata  [2];
    logic        dst_we     [2];
    logic [31:0] dst_addr   [2];
    logic [31:0] dst_wdata  [2];
    logic        acc_cnn_en [2];
    logic        acc_w_en   [2];
    logic [31:0] acc_w_addr [2];
    logic [31:0] acc_wdata  [2];
    logic        acc_r_en   [2];
    logic [31:0] acc_r_addr [2];
    logic        acc_done   [2];
    logic [31:0] acc_rdata0, acc_rdata1;

    cnn_ctrl #(.TIMEOUT(TMO), .ACC_RD_LAT(1)) u_dut (
        .clk(clk), .rst(rst), .start(start[0]), .src_base(src_base[0]), .dst_base(dst_base[0]),
        .busy(busy[0]), .done_o(done_o[0]), .err_timeout(err_timeout[0]),
        .mem_re(mem_re[0]), .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]),
        .dst_we(dst_we[0]), .dst_addr(dst_addr[0]), .dst_wdata(dst_wdata[0]),
        .acc_cnn_en(acc_cnn_en[0]), .acc_w_en(acc_w_en[0]), .acc_w_addr(acc_w_addr[0]),
        .acc_wdata(acc_wdata[0]), .acc_r_en(acc_r_en[0]), .acc_r_addr(acc_r_addr[0]),
        .acc_rdata(acc_rdata0), .acc_done(acc_done[0]));

    cnn_ctrl #(.TIMEOUT(TMO), .ACC_RD_LAT(0)) u_dut_lat0 (
        .clk(clk), .rst(rst), .start(start[1]), .src_base(src_base[1]), .dst_base(dst_base[1]),
        .busy(busy[1]), .done_o(done_o[1]), .err_timeout(err_timeout[1]),
        .mem_re(mem_re[1]), .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]),
        .dst_we(dst_we[1]), .dst_addr(dst_addr[1]), .dst_wdata(dst_wdata[1]),
        .acc_cnn_en(acc_cnn_en[1]), .acc_w_en(acc_w_en[1]), .acc_w_addr(acc_w_addr[1]),
        .acc_wdata(acc_wdata[1]), .acc_r_en(acc_r_en[1]), .acc_r_addr(acc_r_addr[1]),
        .acc_rdata(acc_rdata1), .acc_done(acc_done[1]));

    // ---------------- models ----------------
    int unsigned src_mem [bit [31:0]];

    function automatic logic [31:0] src_rd(input logic [31:0] a);
        if (src_mem.exists(a)) return src_mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic int src_byte(input logic [31:0] a);
        logic [31:0] w;
        w = src_rd(a);
        return int'(w[7:0]);
    endfunction

    // 3x3 valid correlation of the 5x5 image held at sb, kernel following it.
    function automatic logic [15:0] ref_out(input logic [31:0] sb, input int k);
        int s;
        s = 0;
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++)
                s += src_byte(sb + 32'(4 * ((k / 3 + a) * 5 + k % 3 + b))) *
                     src_byte(sb + 32'(4 * (25 + a * 3 + b)));
        return 16'(s);
    endfunction

    int          img [2][25];
    int          ker [2][9];
    logic [15:0] res [2][9];
    int          lat_cnt [2]   = '{0, 0};
    logic        done_lvl[2]   = '{1'b0, 1'b0};
    int          done_mode     = 0;   // 0 model, 1 forced high, 2 forced low

    function automatic logic [15:0] conv(input int g, input int k);
        int s;
        s = 0;
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++)
                s += img[g][(k / 3 + a) * 5 + k % 3 + b] * ker[g][a * 3 + b];
        return 16'(s);
    endfunction

    function automatic logic [15:0] res_at(input int g, input logic [31:0] a);
        logic [31:0] i;
        i = (a - 32'h80) >> 2;
        if (i < 9) return res[g][i];
        return 16'hBAD0;
    endfunction

    always_comb begin
        for (int g = 0; g < 2; g++)
            acc_done[g] = (done_mode == 1) ? 1'b1 : (done_mode == 2) ? 1'b0 : done_lvl[g];
    end

    always_comb begin
        acc_rdata1 = 32'h0;
        if (acc_r_en[1]) acc_rdata1 = {16'h5A5A, res_at(1, acc_r_addr[1])};
    end

    // monitors / logs
    int          cyc = 0;
    int          accw_n[2]   = '{0, 0};
    int          dstw_n[2]   = '{0, 0};
    int          done_n[2]   = '{0, 0};
    int          cnlow_n[2]  = '{0, 0};
    int          kick_cyc[2] = '{0, 0};
    int          err_cyc[2]  = '{0, 0};
    int          rd1_cyc[2]  = '{0, 0};
    logic        rprev[2]    = '{1'b0, 1'b0};
    int          coinc_bad   = 0;
    logic [63:0] wlog [$];
    logic [63:0] dlog0 [$];
    logic [63:0] dlog1 [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (acc_r_en[0]) acc_rdata0 <= {16'hA5A5, res_at(0, acc_r_addr[0])};
        if (dst_we[1] != acc_r_en[1]) coinc_bad <= coinc_bad + 1;
        if (dst_we[0]) dlog0.push_back({dst_addr[0], dst_wdata[0]});
        if (dst_we[1]) dlog1.push_back({dst_addr[1], dst_wdata[1]});
        if (acc_w_en[0]) wlog.push_back({acc_w_addr[0], acc_wdata[0]});
        for (int g = 0; g < 2; g++) begin
            if (mem_re[g]) mem_rdata[g] <= src_rd(mem_addr[g]);
            if (dst_we[g]) dstw_n[g] <= dstw_n[g] + 1;
            if (done_o[g]) done_n[g] <= done_n[g] + 1;
            if (!acc_cnn_en[g]) begin
                cnlow_n[g] <= cnlow_n[g] + 1;
                err_cyc[g] <= cyc;
            end
            if (acc_r_en[g] && !rprev[g]) rd1_cyc[g] <= cyc;
            rprev[g] <= acc_r_en[g];
            if (acc_w_en[g]) begin
                accw_n[g] <= accw_n[g] + 1;
                if (acc_w_addr[g] == 32'h4 && acc_wdata[g][31:16] < 16'd25)
                    img[g][acc_wdata[g][31:16]] <= int'(acc_wdata[g][7:0]);
                else if (acc_w_addr[g] == 32'h8 && acc_wdata[g][31:16] < 16'd9)
                    ker[g][acc_wdata[g][31:16]] <= int'(acc_wdata[g][7:0]);
            end
            if (acc_w_en[g] && acc_w_addr[g] == 32'hC) begin
                for (int k = 0; k < 9; k++) res[g][k] <= conv(g, k);
                lat_cnt[g]  <= 8;
                done_lvl[g] <= 1'b0;
                kick_cyc[g] <= cyc;
            end else if (lat_cnt[g] > 1) begin
                lat_cnt[g] <= lat_cnt[g] - 1;
            end else if (lat_cnt[g] == 1) begin
                lat_cnt[g]  <= 0;
                done_lvl[g] <= 1'b1;
            end
        end
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fill(input logic [31:0] sb, input int kind);
        for (int i = 0; i < 34; i++)
            src_mem[sb + 32'(4 * i)] = (kind == 0) ? ((i < 25) ? i + 1 : i - 24) : $urandom;
    endtask

    task automatic wait_idle(input int g);
        int n;
        n = 0;
        while (busy[g] && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("busy_falls_in_time", {63'b0, busy[g]}, 64'd0);
    endtask

    task automatic run_job(input int g, input logic [31:0] sb, input logic [31:0] db);
        @(negedge clk);
        start[g] = 1'b1; src_base[g] = sb; dst_base[g] = db;
        @(negedge clk);
        start[g] = 1'b0; src_base[g] = $urandom; dst_base[g] = $urandom;
        check("busy_rises", {63'b0, busy[g]}, 64'd1);
        wait_idle(g);
    endtask

    // Accelerator write stream of instance 0 from log index w0.
    task automatic check_wstream(input int w0, input logic [31:0] sb);
        int bad;
        logic [63:0] e;
        logic [31:0] w;
        check("acc_write_count", 64'(wlog.size() - w0), 64'd35);
        if (wlog.size() - w0 >= 35) begin
            bad = -1;
            for (int i = 0; i < 35; i++) begin
                w = src_rd(sb + 32'(4 * i));
                if (i < 25)      e = {32'h4, 16'(i), 8'h00, w[7:0]};
                else if (i < 34) e = {32'h8, 16'(i - 25), 8'h00, w[7:0]};
                else             e = {32'hC, 32'h1};
                if (wlog[w0 + i] !== e && bad < 0) bad = i;
            end
            check("acc_write_stream_first_bad_idx", 64'(bad), 64'(-1));
        end
    endtask

    task automatic check_dst(input int g, input int d0, input logic [31:0] sb, input logic [31:0] db);
        int bad;
        logic [63:0] e, a;
        int sz;
        sz = (g == 0) ? dlog0.size() : dlog1.size();
        check("dst_write_count", 64'(sz - d0), 64'd9);
        if (sz - d0 >= 9) begin
            bad = -1;
            for (int k = 0; k < 9; k++) begin
                a = (g == 0) ? dlog0[d0 + k] : dlog1[d0 + k];
                e = {db + 32'(4 * k), 16'h0, ref_out(sb, k)};
                if (a !== e && bad < 0) bad = k;
            end
            check("dst_contents_first_bad_idx", 64'(bad), 64'(-1));
        end
    endtask

    task automatic check_nominal_consts(input int g, input int d0);
        int exp_nom[9] = '{411, 456, 501, 636, 681, 726, 861, 906, 951};
        logic [63:0] a;
        int sz;
        sz = (g == 0) ? dlog0.size() : dlog1.size();
        if (sz - d0 >= 9) begin
            for (int k = 0; k < 9; k++) begin
                a = (g == 0) ? dlog0[d0 + k] : dlog1[d0 + k];
                check($sformatf("nominal_dst_%0d", k), {32'h0, a[31:0]}, 64'(exp_nom[k]));
            end
        end
    endtask

    typedef struct {
        logic [31:0] sb;
        logic [31:0] db;
        int          fill_kind;  // 0 nominal 1..25/1..9, 1 random
        int          mode;       // accelerator done mode
        logic        exp_done;
        logic        exp_err;
        int          exp_dstw;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        int w0, d0, dn, cl, aw, dw, cb;
        logic [31:0] rb;

        for (int g = 0; g < 2; g++) begin
            start[g] = 1'b0; src_base[g] = '0; dst_base[g] = '0;
        end
        rb = 32'h0100_0000 | ($urandom & 32'h00FF_FFFF);
        tbl[0] = '{32'h0000_1000, 32'h0000_2000, 0, 0, 1'b1, 1'b0, 9};
        tbl[1] = '{rb,            32'h0000_3000, 1, 0, 1'b1, 1'b0, 9};
        tbl[2] = '{32'hFFFF_FFC0, 32'hFFFF_FFF0, 1, 0, 1'b1, 1'b0, 9};
        tbl[3] = '{32'h0000_1000, 32'h0000_4000, 0, 2, 1'b0, 1'b1, 0};
        tbl[4] = '{32'h0000_5000, 32'h0000_6000, 1, 0, 1'b1, 1'b0, 9};
        tbl[5] = '{32'h0200_0003, 32'h0000_6100, 1, 0, 1'b1, 1'b0, 9};

        // reset state, sampled mid-cycle while rst is low
        #12;
        for (int g = 0; g < 2; g++) begin
            check("reset_flags", {56'b0, busy[g], done_o[g], err_timeout[g], mem_re[g],
                  acc_w_en[g], acc_r_en[g], dst_we[g], acc_cnn_en[g]}, 64'h01);
            check("reset_addr_data", {32'h0, mem_addr[g] | dst_addr[g] | dst_wdata[g] |
                  acc_w_addr[g] | acc_wdata[g] | acc_r_addr[g]}, 64'h0);
        end
        @(negedge clk);
        rst = 1'b1;

        // table-driven jobs on instance 0
        for (int r = 0; r < 6; r++) begin
            fill(tbl[r].sb, tbl[r].fill_kind);
            done_mode = tbl[r].mode;
            if (r == 4) check("err_sticky_before_next_start", {63'b0, err_timeout[0]}, 64'd1);
            w0 = wlog.size(); d0 = dlog0.size(); dn = done_n[0]; cl = cnlow_n[0]; dw = dstw_n[0];
            run_job(0, tbl[r].sb, tbl[r].db);
            check($sformatf("row%0d_done_pulses", r), 64'(done_n[0] - dn), 64'(tbl[r].exp_done));
            check($sformatf("row%0d_err_timeout", r), {63'b0, err_timeout[0]}, {63'b0, tbl[r].exp_err});
            check($sformatf("row%0d_dst_writes", r), 64'(dstw_n[0] - dw), 64'(tbl[r].exp_dstw));
            check_wstream(w0, tbl[r].sb);
            if (tbl[r].exp_err) begin
                check("timeout_cnn_en_low_cycles", 64'(cnlow_n[0] - cl), 64'd1);
                check("timeout_err_after_kick", 64'(err_cyc[0] - kick_cyc[0]), 64'd17);
            end else begin
                check("cnn_en_stays_high", 64'(cnlow_n[0] - cl), 64'd0);
                check_dst(0, d0, tbl[r].sb, tbl[r].db);
            end
            if (r == 0) begin
                check("nom_first_img", wlog[w0], {32'h4, 32'h0000_0001});
                check("nom_last_img", wlog[w0 + 24], {32'h4, 32'h0018_0019});
                check("nom_first_ker", wlog[w0 + 25], {32'h8, 32'h0000_0001});
                check("nom_last_ker", wlog[w0 + 33], {32'h8, 32'h0008_0009});
                check("nom_kick", wlog[w0 + 34], {32'hC, 32'h1});
                check_nominal_consts(0, d0);
            end
        end
        done_mode = 0;

        // stale done: acc_done high throughout
        fill(32'h0000_1000, 0);
        done_mode = 1;
        d0 = dlog0.size();
        run_job(0, 32'h0000_1000, 32'h0000_7000);
        check("stale_first_read_after_kick", 64'(rd1_cyc[0] - kick_cyc[0]), 64'd3);
        check_dst(0, d0, 32'h0000_1000, 32'h0000_7000);
        done_mode = 0;

        // start pulses during LD_IMG element 5 and during WAIT are ignored
        w0 = wlog.size(); d0 = dlog0.size(); dn = done_n[0]; aw = accw_n[0];
        @(negedge clk);
        start[0] = 1'b1; src_base[0] = 32'h0000_1000; dst_base[0] = 32'h0000_7100;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (5) @(negedge clk);
        start[0] = 1'b1; src_base[0] = 32'h0000_8000; dst_base[0] = 32'h0000_9000;
        @(negedge clk);
        start[0] = 1'b0;
        for (int n = 0; n < 100 && accw_n[0] - aw < 35; n++) @(negedge clk);
        check("reached_wait", 64'(accw_n[0] - aw), 64'd35);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_idle(0);
        repeat (3) @(negedge clk);
        check("ignored_start_no_extra_job", {63'b0, busy[0]}, 64'd0);
        check("ignored_start_done_once", 64'(done_n[0] - dn), 64'd1);
        check_wstream(w0, 32'h0000_1000);
        check_dst(0, d0, 32'h0000_1000, 32'h0000_7100);

        // asynchronous reset in LD_KER
        @(negedge clk);
        start[0] = 1'b1; src_base[0] = 32'h0000_1000; dst_base[0] = 32'h0000_7200;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (28) @(negedge clk);
        check("in_ld_ker_before_reset", {31'b0, acc_w_en[0], acc_w_addr[0]}, {31'b0, 1'b1, 32'h8});
        #2 rst = 1'b0;
        #1;
        check("async_reset_strobes", {57'b0, mem_re[0], acc_w_en[0], acc_r_en[0], dst_we[0],
              busy[0], done_o[0], acc_cnn_en[0]}, 64'h01);
        @(negedge clk);
        rst = 1'b1;
        w0 = wlog.size(); d0 = dlog0.size();
        run_job(0, 32'h0000_1000, 32'h0000_A000);
        check_wstream(w0, 32'h0000_1000);
        check_dst(0, d0, 32'h0000_1000, 32'h0000_A000);

        // ACC_RD_LAT = 0 instance: nominal then randomized jobs
        for (int r = 0; r < 3; r++) begin
            rb = (r == 0) ? 32'h0000_1000 : $urandom;
            fill(rb, (r == 0) ? 0 : 1);
            d0 = dlog1.size(); dn = done_n[1]; cb = coinc_bad;
            run_job(1, rb, 32'h0000_B000 + 32'(r * 64));
            check("lat0_done_once", 64'(done_n[1] - dn), 64'd1);
            check("lat0_dst_we_with_r_en", 64'(coinc_bad - cb), 64'd0);
            check_dst(1, d0, rb, 32'h0000_B000 + 32'(r * 64));
            if (r == 0) check_nominal_consts(1, d0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cnn_ctrl.md
Name: cnn_ctrl

Overview:
Sequencer that runs one complete convolution job on cnn_accel without CPU involvement. On a start pulse it streams the image and kernel bytes from a source memory into the accelerator's register port and triggers the convolution. It then waits for the accelerator's done flag and copies the results to a destination memory. It sits between the system bus/memories and cnn_accel and fully owns the accelerator's write and read ports while busy.

Parameters:
IMG_N, 25, number of image pixels written (5x5)
KER_N, 9, number of kernel taps written (3x3)
OUT_N, 9, number of result words read back
TIMEOUT, 4096, maximum WAIT cycles before aborting
ACC_RD_LAT, 1, cycles from acc_r_en/acc_r_addr to a valid acc_rdata (0 or 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  single-cycle job request
src_base  in  32  byte address of the first source word (sampled on start)
dst_base  in  32  byte address of the first result word (sampled on start)
busy  out  1  high from the start-accept cycle until FIN/ERR completes
done_o  out  1  one-cycle pulse on successful completion
err_timeout  out  1  sticky; set on timeout, cleared on the next accepted start
mem_re  out  1  source read strobe
mem_addr  out  32  source byte address
mem_rdata  in  32  source data; valid the cycle after mem_re; bits [7:0] used
dst_we  out  1  result write strobe
dst_addr  out  32  result byte address
dst_wdata  out  32  {16'b0, result[15:0]}
acc_cnn_en  out  1  accelerator enable
acc_w_en  out  1  accelerator write strobe
acc_w_addr  out  32  accelerator write address
acc_wdata  out  32  accelerator write data
acc_r_en  out  1  accelerator read strobe
acc_r_addr  out  32  accelerator read address
acc_rdata  in  32  accelerator read data; bits [15:0] used
acc_done  in  1  accelerator completion level

Behaviour:
- Reset (asynchronous, any state): state to IDLE; all counters 0; every output 0, except acc_cnn_en = 1 (see ERR for its only deassertion).
- IDLE: start=1 latches src_base and dst_base, clears err_timeout, sets busy on the next edge, and moves to LD_IMG. start is ignored in every other state.
- LD_IMG: pipelined copy.
  - Cycle i (i = 0..IMG_N-1): mem_re=1, mem_addr = src_base + 4*i.
  - Cycle i+1: acc_w_en=1, acc_w_addr=0x004, acc_wdata = {i[15:0], 8'h00, mem_rdata[7:0]}.
  - Duration is IMG_N+1 cycles. The last write overlaps the first kernel read.
- LD_KER: same scheme. For j = 0..KER_N-1: mem_addr = src_base + 4*(IMG_N+j), acc_w_addr=0x008, acc_wdata = {j[15:0], 8'h00, mem_rdata[7:0]}.
- KICK (1 cycle): acc_w_en=1, acc_w_addr=0x00C, acc_wdata=32'h1.
- WAIT:
  - acc_done is ignored in the first WAIT cycle, because a stale done from the previous job is possible.
  - acc_done=1 in any later cycle moves to RD_RES.
  - A cycle counter, cleared on entry, moves to ERR when it reaches TIMEOUT-1 with acc_done still 0.
  - If acc_done and the timeout condition coincide, acc_done wins.
- RD_RES:
  - For k = 0..OUT_N-1: acc_r_en=1, acc_r_addr = 0x080 + 4*k.
  - ACC_RD_LAT cycles later: dst_we=1, dst_addr = dst_base + 4*k, dst_wdata = {16'b0, acc_rdata[15:0]}.
  - Reads are issued back to back. Duration is OUT_N+ACC_RD_LAT cycles.
- FIN (1 cycle): done_o=1, busy=0 on the next edge, return to IDLE.
- ERR (1 cycle): err_timeout=1 (sticky), acc_cnn_en=0 for this cycle only as a soft clear, no dst writes, return to IDLE.
- Strobe exclusivity: outside their state windows, acc_w_en, acc_r_en, mem_re and dst_we are 0. Address and data outputs may hold their last value.
- Address arithmetic: 32-bit modulo 2^32; wrap-around is allowed and not flagged.
- Index fields: zero-extended to 16 bits.

Decomposition:
- Package cnn_pkg:
  - Accelerator register offsets: IMG_ADDR 0x004, KER_ADDR 0x008, START_ADDR 0x00C, RES_BASE 0x080.
  - Controller state encoding: IDLE, LD_IMG, LD_KER, KICK, WAIT, RD_RES, FIN, ERR.
  - Word stride constant: 4.
- No sub-module. One shared element counter is used by LD_IMG, LD_KER and RD_RES, and a separate WAIT timeout counter.
- Flat RTL, about 200 lines.

Test Plan:
1. Nominal job. src words 1..25 then 1..9, src_base=0x1000, dst_base=0x2000, correlating accelerator model.
   - Required accelerator writes: first 0x00000001 @0x004; last image 0x00180019; first kernel 0x00000001 @0x008; last kernel 0x00080009; 0x1 @0x00C.
   - Required dst contents: 0x2000..0x2020 = 411, 456, 501, 636, 681, 726, 861, 906, 951.
   - done_o pulses exactly once.
2. Timeout. TIMEOUT=16, acc_done held 0.
   - ERR is entered 16 cycles after WAIT entry, then err_timeout=1 and busy=0.
   - acc_cnn_en is low for 1 cycle, there are zero dst writes, and done_o stays 0.
   - A following good job clears err_timeout.
3. Stale done. acc_done held high at start and kept high.
   - The controller does not leave WAIT on its first cycle and proceeds to RD_RES on the second.
4. start pulses at LD_IMG element 5 and during WAIT are ignored.
   - Exactly 25 + 9 + 1 accelerator writes occur, and the latched bases are unchanged.
5. rst driven low mid LD_KER.
   - All strobes are 0 immediately (asynchronously), busy=0 and acc_cnn_en=1.
   - A fresh start then runs the full sequence correctly.
6. ACC_RD_LAT=0 with a combinational accelerator read model.
   - dst_we is coincident with acc_r_en, and the dst values match scenario 1.
